// File: rtl/hc_sr04_pkg.sv
// Shared state encodings and default timing constants for the HC-SR04 emulator and controller.
package hc_sr04_pkg;

  // Default timing, in 12 MHz clocks
  localparam int unsigned DEF_TEN_US         = 120;
  localparam int unsigned DEF_BURST_CYCLES   = 2400;
  localparam int unsigned DEF_CYC_PER_CM     = 696;
  localparam int unsigned DEF_MAX_CM         = 400;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 456000;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 12000;

  // Counter widths
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned WID_W  = 10;
  localparam int unsigned DIST_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

endpackage

// File: rtl/hc_sr04_emulator_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc_sr04_emulator.sv
// HC-SR04 ultrasonic sensor emulator: TRIG in, distance-proportional ECHO pulse out.
module hc_sr04_emulator
  import hc_sr04_pkg::*;
#(
  parameter int unsigned TEN_US         = DEF_TEN_US,
  parameter int unsigned BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int unsigned CYC_PER_CM     = DEF_CYC_PER_CM,
  parameter int unsigned MAX_CM         = DEF_MAX_CM,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [DIST_W-1:0] distance_cm,
  input  logic              en,
  output logic              echo,
  output logic              busy,
  output logic              runt,
  output logic [2:0]        state
);

  logic trig_s;

  state_t            st_q, st_n;
  logic              echo_n, busy_n, runt_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CNT_W-1:0]  width_q, width_n;
  logic [WID_W-1:0]  wcnt_q, wcnt_n;
  logic [DIST_W-1:0] cm_q, cm_n;
  logic              blocked_q, blocked_n;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trig),
    .q     (trig_s)
  );

  assign state = st_q;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      echo      <= 1'b0;
      busy      <= 1'b0;
      runt      <= 1'b0;
      cnt_q     <= '0;
      width_q   <= '0;
      wcnt_q    <= '0;
      cm_q      <= '0;
      blocked_q <= 1'b0;
    end else begin
      st_q      <= st_n;
      echo      <= echo_n;
      busy      <= busy_n;
      runt      <= runt_n;
      cnt_q     <= cnt_n;
      width_q   <= width_n;
      wcnt_q    <= wcnt_n;
      cm_q      <= cm_n;
      blocked_q <= blocked_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    st_n      = st_q;
    echo_n    = echo;
    runt_n    = 1'b0;
    cnt_n     = cnt_q;
    width_n   = width_q;
    wcnt_n    = wcnt_q;
    cm_n      = cm_q;
    blocked_n = blocked_q;

    unique case (st_q)
      ST_IDLE: begin
        echo_n = 1'b0;
        // A TRIG left high across HOLDOFF must be seen low before re-arming
        if (!trig_s) blocked_n = 1'b0;
        if (en && trig_s && !blocked_q) begin
          st_n   = ST_TRIG_HI;
          wcnt_n = WID_W'(1);
        end
      end

      ST_TRIG_HI: begin
        if (trig_s) begin
          if (wcnt_q < WID_W'(TEN_US)) wcnt_n = wcnt_q + WID_W'(1);
        end else if (wcnt_q >= WID_W'(TEN_US)) begin
          cm_n  = distance_cm;
          cnt_n = '0;
          st_n  = ST_BURST;
        end else begin
          runt_n = 1'b1;
          st_n   = ST_IDLE;
        end
      end

      ST_BURST: begin
        // Range-checked operand keeps the product within the counter width
        if (cnt_q == '0) begin
          if (cm_q >= DIST_W'(1) && cm_q <= DIST_W'(MAX_CM))
            width_n = CNT_W'(cm_q) * CNT_W'(CYC_PER_CM);
          else
            width_n = CNT_W'(TIMEOUT_CYCLES);
        end
        if (cnt_q == CNT_W'(BURST_CYCLES - 1)) begin
          echo_n = 1'b1;
          cnt_n  = '0;
          st_n   = ST_ECHO;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_ECHO: begin
        if (cnt_q == width_q - CNT_W'(1)) begin
          echo_n = 1'b0;
          cnt_n  = '0;
          st_n   = ST_HOLDOFF;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          cnt_n     = '0;
          blocked_n = 1'b1;
          st_n      = ST_IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        echo_n = 1'b0;
        cnt_n  = '0;
        st_n   = ST_IDLE;
      end
    endcase

    busy_n = (st_n != ST_IDLE);
  end

endmodule

// File: tb/tb_hc_sr04_emulator.sv
// Self-checking bench for hc_sr04_emulator with scaled-down timing.
module tb_hc_sr04_emulator;

  localparam int TEN_US  = 12;
  localparam int BURST   = 40;
  localparam int CYC     = 7;
  localparam int MAX_CM  = 30;
  localparam int TIMEOUT = 250;
  localparam int HOLDOFF = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] distance_cm = '0;
  logic        en = 1'b0;
  logic        echo, busy, runt;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int len; int cm; bit en;
    int s2; int l2; int s3; int l3;
    bit runt; int w;
  } tvec_t;

  tvec_t tab[12];

  hc_sr04_emulator #(
    .TEN_US(TEN_US), .BURST_CYCLES(BURST), .CYC_PER_CM(CYC),
    .MAX_CM(MAX_CM), .TIMEOUT_CYCLES(TIMEOUT), .HOLDOFF_CYCLES(HOLDOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
    .en(en), .echo(echo), .busy(busy), .runt(runt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference: echo width from distance
  function automatic int exp_width(int cm);
    return (cm >= 1 && cm <= MAX_CM) ? cm * CYC : TIMEOUT;
  endfunction

  function automatic tvec_t mk(int len, int cm, bit e, int s2, int l2, int s3, int l3, bit r, int w);
    tvec_t v;
    v.len = len; v.cm = cm; v.en = e; v.s2 = s2; v.l2 = l2; v.s3 = s3; v.l3 = l3;
    v.runt = r; v.w = w;
    return v;
  endfunction

  function automatic bit trig_at(tvec_t v, int c);
    return (c >= 1 && c <= v.len) ||
           (v.l2 > 0 && c >= v.s2 && c < v.s2 + v.l2) ||
           (v.l3 > 0 && c >= v.s3 && c < v.s3 + v.l3);
  endfunction

  // Drive one TRIG scenario (called #1 after a posedge) and check event timing
  task automatic run_meas(input tvec_t v, input string tag);
    int rise = -1, fall = -1, bdrop = -1, bfirst = -1, runt_cyc = -1;
    int echo_rises = 0, busy_rises = 0, runt_cnt = 0;
    bit pe = 1'b0, pb = 1'b0;
    int win = v.len + 3 + BURST + TIMEOUT + HOLDOFF + 60;
    if (v.l2 > 0 && v.s2 + v.l2 + 40 > win) win = v.s2 + v.l2 + 40;
    if (v.l3 > 0 && v.s3 + v.l3 + 40 > win) win = v.s3 + v.l3 + 40;
    en = v.en;
    distance_cm = 16'(v.cm);
    trig = 1'b1;
    for (int c = 1; c <= win; c++) begin
      @(posedge clk); #1;
      if (echo && !pe) begin echo_rises++; if (rise < 0) rise = c; end
      if (!echo && pe && fall < 0) fall = c;
      if (busy && !pb) begin busy_rises++; if (bfirst < 0) bfirst = c; end
      if (!busy && pb && bdrop < 0) bdrop = c;
      if (runt) begin runt_cnt++; if (runt_cyc < 0) runt_cyc = c; end
      pe = echo; pb = busy;
      if (c == v.len + 5) distance_cm = 16'($urandom);
      if (v.en && c == v.len + 6) en = 1'b0;
      if (v.en && c == v.len + 10 + BURST) en = 1'b1;
      trig = trig_at(v, c + 1);
    end
    if (!v.en) begin
      check({tag, "_noen_busy"}, busy_rises, 0);
      check({tag, "_noen_echo"}, echo_rises, 0);
      check({tag, "_noen_runt"}, runt_cnt, 0);
    end else if (v.runt) begin
      check({tag, "_runt_cnt"}, runt_cnt, 1);
      check({tag, "_runt_cyc"}, runt_cyc, v.len + 3);
      check({tag, "_runt_echo"}, echo_rises, 0);
      check({tag, "_runt_bfirst"}, bfirst, 3);
      check({tag, "_runt_bdrop"}, bdrop, v.len + 3);
    end else begin
      check({tag, "_bfirst"}, bfirst, 3);
      check({tag, "_rise"}, rise, v.len + 3 + BURST);
      check({tag, "_width"}, fall - rise, v.w);
      check({tag, "_holdoff"}, bdrop - fall, HOLDOFF);
      check({tag, "_echo_cnt"}, echo_rises, 1);
      check({tag, "_busy_cnt"}, busy_rises, 1);
      check({tag, "_no_runt"}, runt_cnt, 0);
    end
    check({tag, "_end_state"}, int'(state), 0);
    check({tag, "_end_busy"}, int'(busy), 0);
  endtask

  initial begin
    tvec_t rv;
    int seen;

    // len, cm, en, s2, l2, s3, l3, runt, width
    tab[0]  = mk(12, 10,    1, 0, 0, 0, 0, 0, 70);
    tab[1]  = mk(11, 5,     1, 0, 0, 0, 0, 1, 0);
    tab[2]  = mk(1,  5,     1, 0, 0, 0, 0, 1, 0);
    tab[3]  = mk(12, 0,     1, 0, 0, 0, 0, 0, 250);
    tab[4]  = mk(13, 31,    1, 0, 0, 0, 0, 0, 250);
    tab[5]  = mk(12, 30,    1, 0, 0, 0, 0, 0, 210);
    tab[6]  = mk(14, 1,     1, 0, 0, 0, 0, 0, 7);
    tab[7]  = mk(12, 65535, 1, 0, 0, 0, 0, 0, 250);
    tab[8]  = mk(40, 3,     1, 0, 0, 0, 0, 0, 21);
    tab[9]  = mk(12, 10,    0, 0, 0, 0, 0, 0, 0);
    tab[10] = mk(12, 10,    1, 20, 20, 60, 15, 0, 70);
    tab[11] = mk(12, 2,     1, 74, 60, 0, 0, 0, 14);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_echo", int'(echo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_runt", int'(runt), 0);
    check("rst_state", int'(state), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_meas(tab[i], $sformatf("vec%0d", i));

    // Randomised scenarios against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      rv = mk(int'($urandom_range(TEN_US + 20, TEN_US - 3)), int'($urandom_range(MAX_CM + 5, 0)),
              ($urandom_range(7, 0) != 0), 0, 0, 0, 0, 1'b0, 0);
      rv.runt = (rv.len < TEN_US);
      rv.w = exp_width(rv.cm);
      run_meas(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of ECHO
    en = 1'b1;
    distance_cm = 16'd20;
    trig = 1'b1;
    repeat (12) @(posedge clk);
    #1 trig = 1'b0;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (echo) seen = 1;
    end
    check("mid_echo_seen", seen, 1);
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_echo", int'(echo), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_state", int'(state), 0);
    trig = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_hold_echo", int'(echo), 0);
    check("mid_rst_hold_state", int'(state), 0);
    rst_n = 1'b1;
    run_meas(mk(12, 7, 1, 0, 0, 0, 0, 0, 49), "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hc_sr04_emulator.md
HC_SR04_EMULATOR -- requirements
Module: hc_sr04_emulator

Interface
REQ-001 SHALL have parameter TEN_US, default 10'd120: minimum valid TRIG high width in clocks (~10 us at 12 MHz).
REQ-002 SHALL have parameter BURST_CYCLES, default 2400: TRIG-fall to ECHO-rise delay (~200 us at 12 MHz).
REQ-003 SHALL have parameter CYC_PER_CM, default 696: ECHO clocks per cm (58 us round trip).
REQ-004 SHALL have parameter MAX_CM, default 400: largest in-range distance.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 456000: no-target ECHO width (38 ms).
REQ-006 SHALL have parameter HOLDOFF_CYCLES, default 12000: dead time after ECHO falls (1 ms).
REQ-007 SHALL have port clk, input, 1: ~12 MHz clock, the only clock.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port trig, input, 1: TRIG from the initiator, asynchronous to clk.
REQ-010 SHALL have port distance_cm, input, 16: emulated target distance, sampled once per measurement.
REQ-011 SHALL have port en, input, 1: when low, trig is ignored while in IDLE.
REQ-012 SHALL have port echo, output, 1: ECHO pin to the initiator, registered.
REQ-013 SHALL have port busy, output, 1: high whenever state != IDLE.
REQ-014 SHALL have port runt, output, 1: one-cycle pulse on a TRIG shorter than TEN_US.
REQ-015 SHALL have port state, output, 3: debug copy of the FSM state.

Function
REQ-016 SHALL pass trig through a 2-flop synchronizer; all following timing refers to the synchronized trig_s.
REQ-017 SHALL implement the states IDLE, TRIG_HI, BURST, ECHO and HOLDOFF.
REQ-018 IDLE: when en=1 and trig_s=1, SHALL go to TRIG_HI with the width counter cleared to 1.
REQ-019 TRIG_HI: SHALL increment the width counter while trig_s=1, saturating at TEN_US.
REQ-020 TRIG_HI, on trig_s=0 with width >= TEN_US: SHALL latch distance_cm and go to BURST.
REQ-021 TRIG_HI, on trig_s=0 with width < TEN_US: SHALL pulse runt for 1 cycle and return to IDLE; echo stays low.
REQ-022 BURST: SHALL count BURST_CYCLES clocks, then assert echo and enter ECHO on the same edge.
REQ-023 SHALL compute the echo width once, registered during BURST, as latched_cm * CYC_PER_CM when 1 <= latched_cm <= MAX_CM, else TIMEOUT_CYCLES.
REQ-024 SHALL size the width counter to 20 bits unsigned; the product fits in 19 bits because the operand is range-checked first.
REQ-025 ECHO: SHALL hold echo high for exactly the computed number of clocks, then deassert it and enter HOLDOFF.
REQ-026 HOLDOFF: SHALL count HOLDOFF_CYCLES clocks, then return to IDLE.
REQ-027 SHALL ignore trig activity in BURST, ECHO and HOLDOFF; no restart and no runt pulse.
REQ-028 SHALL sample en only in IDLE; deasserting en mid-measurement does not abort it.
REQ-029 SHALL ignore distance_cm changes after the latch.
REQ-030 If trig_s is still high when HOLDOFF ends, SHALL stay in IDLE until trig_s has been seen low, so no re-trigger from a stuck-high TRIG.
REQ-031 SHALL return any illegal state encoding to IDLE on the next clock.

Reset
REQ-032 On rst_n=0, SHALL asynchronously force state=IDLE, echo=0, busy=0, runt=0, all counters=0, latched distance=0, synchronizer flops=0.
REQ-033 Reset during any state, including mid-ECHO, SHALL drop echo immediately with no partial pulse resumed.
REQ-034 After rst_n rises, SHALL accept a TRIG no earlier than the third clock edge, due to the synchronizer.

Structure
REQ-035 SHALL place the FSM state encodings and the default timing constants (TEN_US, BURST_CYCLES, CYC_PER_CM, MAX_CM, TIMEOUT_CYCLES, HOLDOFF_CYCLES) in shared package hc_sr04_pkg, reused by the hc_sr04 controller bench.
REQ-036 SHALL instantiate one sub-module, sync_2ff, for the trig synchronizer; all other logic stays flat.

Verification
REQ-037 trig high 120 clk, distance_cm=10 -> echo rises BURST_CYCLES (2400) clk after leaving TRIG_HI; echo high exactly 6960 clk; busy drops 12000 clk after echo falls.
REQ-038 trig high 50 clk -> runt pulses 1 clk; echo stays low; state returns to IDLE.
REQ-039 distance_cm=0 and distance_cm=401 -> echo width 456000 clk; distance_cm=400 -> 278400 clk.
REQ-040 Second trig pulse during BURST, then another during ECHO -> single echo with unchanged width; runt never asserts.
REQ-041 rst_n low for 3 clk midway through ECHO -> echo=0 asynchronously; state=IDLE; a new 120-clk trig yields a correct full measurement.
REQ-042 Closed loop with the hc_sr04 controller at distance_cm=25 -> the controller's distance_raw equals the emulated echo width of 17400 clk (±1).
